bin_to_bcd_seq: RTL and testbench
=================================

// Module: bin_to_bcd_seq
// PURPOSE
//  Sequential, parametrised binary-to-BCD converter (shift-add-3 / double-dabble).
//  Generalises the fixed 5-bit, 2-digit volume decoder to any input width and digit count.
//  Adds a start/busy/done handshake, overflow saturation and a leading-zero blank mask.
//  Sits between counters/volume registers and the seven-segment scan driver.
// PARAMETERS
//  WIDTH   8  binary input width in bits (>=1)
//  DIGITS  3  number of BCD output digits (>=1); LIMIT = 10**DIGITS, computed at elaboration
// PORTS
//  clk     in   1           system clock, all logic on rising edge
//  rst     in   1           synchronous, active-high reset
//  start   in   1           request conversion of bin; honoured only in IDLE
//  bin     in   WIDTH       unsigned binary value, sampled on the accepted start edge only
//  busy    out  1           1 while in SHIFT or DONE; start is ignored while busy=1
//  done    out  1           single-cycle pulse: bcd/ovf/blank updated this cycle
//  bcd     out  4*DIGITS    packed digits; bcd[3:0] = units, bcd[4*DIGITS-1 -: 4] = most significant
//  ovf     out  1           1 if the last converted value was >= LIMIT
//  blank   out  DIGITS      bit i = 1 if digit i is a leading zero; blank[0] is always 0
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, done=0, bcd=0, ovf=0, blank={DIGITS-1{1'b1},1'b0}; counter and shift reg cleared.
//  FSM, one clock, three states:
//   IDLE : start=1 -> latch bin into the low WIDTH bits of the shift reg (BCD field = 0),
//          counter=WIDTH, ovf_next = (bin >= LIMIT), go SHIFT. start=0 -> stay.
//   SHIFT: each cycle, every BCD digit >= 5 gets +3, then the whole reg shifts left 1.
//          counter decrements; after the WIDTH-th shift go DONE.
//   DONE : register outputs, done=1 for exactly this cycle, go IDLE.
//  Latency: start accepted at edge N -> done=1 in the cycle after edge N+WIDTH+1.
//   Next start is accepted at the earliest at edge N+WIDTH+2 (throughput 1 per WIDTH+2 cycles).
//  Outputs bcd/ovf/blank hold their last value between done pulses; they never show partial results.
//  Width: shift reg is 4*DIGITS+WIDTH bits; top-digit carry-out is discarded.
//   Correctness relies on the ovf path, not on the carry-out.
//  Overflow: if ovf_next=1, bcd = all digits 4'd9 (saturate), ovf=1; otherwise bcd = exact result, ovf=0.
//  Blank: computed from the final bcd (after saturation), scanning from the MS digit down;
//   stops at the first non-zero digit; digit 0 is never blanked (bin=0 shows "0").
//  start held high: converts again from IDLE after each done (back-to-back, bin re-sampled each time).
//  start while busy: ignored, not queued.
//  bin changes during SHIFT: no effect on the current conversion.
//  rst during SHIFT/DONE: aborts, no done pulse, outputs return to their reset values the next cycle.
//  rst and start in the same cycle: rst wins.
//  No combinational path from start or bin to any output.
// STRUCTURE
//  Shared package bcd_pkg: BCD_DIGIT_W=4, state encodings S_IDLE/S_SHIFT/S_DONE,
//   and a constant function pow10(n) used for LIMIT.
//  Sub-module bcd_add3: 4-bit in/out, combinational, adds 3 when in >= 5; instantiated DIGITS times
//   via a generate loop.
//  Top holds the FSM, counter ($clog2(WIDTH+1) bits), shift reg, output regs and blank logic.
// TESTING
//  W=8,D=3: start with bin=255 -> done in the cycle after edge WIDTH+1 (9) post-start;
//   bcd=12'h255, ovf=0, blank=3'b000, busy=1 over the window.
//  W=8,D=3: bin=0 -> bcd=12'h000, blank=3'b110.
//   bin=7 -> bcd=12'h007, blank=3'b110.
//   bin=40 -> bcd=12'h040, blank=3'b100.
//  W=8,D=2: bin=99 -> bcd=8'h99, ovf=0.
//   bin=100 -> bcd=8'h99, ovf=1.
//   bin=123 -> bcd=8'h99, ovf=1.
//  W=5,D=2: sweep bin=0..31 back-to-back with start held high;
//   each result matches the tens/units decode (31 -> 8'h31), one done per conversion.
//  Start with bin=200, then pulse start with bin=17 mid-conversion and change bin each cycle
//   -> second start ignored, single done, bcd=12'h200.
//  Assert rst at SHIFT cycle 4 -> no done, next cycle busy=0 and bcd=0;
//   a new start with bin=58 -> bcd=12'h058.

Source files
------------

// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
// Shared definitions for the sequential binary-to-BCD converter:
//   BCD_DIGIT_W : width of one packed BCD digit
//   state_t     : converter FSM encodings (S_IDLE / S_SHIFT / S_DONE)
//   pow10(n)    : constant function, 10**n as a 64-bit unsigned value
// -----------------------------------------------------------------------------
package bcd_pkg;

   localparam int BCD_DIGIT_W = 4;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   // Evaluated at elaboration to size the overflow limit for DIGITS digits.
   function automatic logic [63:0] pow10(input int n);
      logic [63:0] r;
      r = 64'd1;
      for (int i = 0; i < n; i++) begin
         r = r * 64'd10;
      end
      return r;
   endfunction

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_seq_if
// Request/result bundle of the binary-to-BCD converter.
//   start  : request a conversion (master -> slave)
//   bin    : unsigned binary value, WIDTH bits (master -> slave)
//   busy   : conversion in progress (slave -> master)
//   done   : one-cycle pulse, results updated (slave -> master)
//   bcd    : packed BCD digits, units in the low nibble (slave -> master)
//   ovf    : last value did not fit in DIGITS digits (slave -> master)
//   blank  : per-digit leading-zero mask (slave -> master)
// -----------------------------------------------------------------------------
interface bin_to_bcd_seq_if
   import bcd_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
);
   logic                          start;
   logic [WIDTH-1:0]              bin;
   logic                          busy;
   logic                          done;
   logic [BCD_DIGIT_W*DIGITS-1:0] bcd;
   logic                          ovf;
   logic [DIGITS-1:0]             blank;

   modport master (output start, bin, input busy, done, bcd, ovf, blank);
   modport slave  (input start, bin, output busy, done, bcd, ovf, blank);
endinterface

// File: rtl/bcd_add3.sv
// -----------------------------------------------------------------------------
// bcd_add3
// Combinational double-dabble correction for one BCD digit: adds 3 when the
// digit is 5 or more, so that the following left shift carries correctly.
//   din  : BCD digit before correction
//   dout : corrected digit
// -----------------------------------------------------------------------------
module bcd_add3
   import bcd_pkg::*;
(
   input  logic [BCD_DIGIT_W-1:0] din,
   output logic [BCD_DIGIT_W-1:0] dout
);
   assign dout = (din >= 4'd5) ? din + 4'd3 : din;
endmodule

// File: rtl/bin_to_bcd_seq.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_seq
// Sequential shift-add-3 binary-to-BCD converter, one bit per clock.
// Saturates to all nines when the value does not fit in DIGITS digits and
// produces a leading-zero blank mask for the seven-segment scan driver.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : bin_to_bcd_seq_if slave (start/bin in; busy/done/bcd/ovf/blank out)
// -----------------------------------------------------------------------------
module bin_to_bcd_seq
   import bcd_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
) (
   input  logic             clk,
   input  logic             rst,
   bin_to_bcd_seq_if.slave  bus
);
   localparam int          BCD_W = BCD_DIGIT_W * DIGITS;
   localparam int          SR_W  = BCD_W + WIDTH;
   localparam int          CNT_W = $clog2(WIDTH + 1);
   localparam logic [63:0] LIMIT = pow10(DIGITS);
   localparam logic [BCD_W-1:0]  ALL_NINES = {DIGITS{4'h9}};
   // Every digit above the units marked as leading zero; units never blanked.
   localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [SR_W-1:0]    sr;
   logic [SR_W-1:0]    sr_adj;
   logic               ovf_pend;
   logic               busy_q;
   logic               done_q;
   logic [BCD_W-1:0]   bcd_q;
   logic               ovf_q;
   logic [DIGITS-1:0]  blank_q;

   logic [63:0]        bin_ext;
   logic               ovf_cmp;
   logic [BCD_W-1:0]   bcd_final;
   logic [DIGITS-1:0]  blank_final;

   // Scan from the most significant digit down; stop at the first non-zero.
   function automatic logic [DIGITS-1:0] blank_of(input logic [BCD_W-1:0] v);
      logic [DIGITS-1:0] m;
      logic              lead;
      m    = '0;
      lead = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         if (lead && (v[BCD_DIGIT_W*i +: BCD_DIGIT_W] == 4'd0)) begin
            m[i] = 1'b1;
         end else begin
            lead = 1'b0;
         end
      end
      return m;
   endfunction

   // Overflow is decided from the input value; the top-digit carry-out of the
   // shift register is simply dropped.
   assign bin_ext = 64'(bus.bin);
   assign ovf_cmp = (bin_ext >= LIMIT);

   assign sr_adj[WIDTH-1:0] = sr[WIDTH-1:0];
   for (genvar g = 0; g < DIGITS; g++) begin : g_add3
      bcd_add3 u_add3 (
         .din  (sr[WIDTH + BCD_DIGIT_W*g +: BCD_DIGIT_W]),
         .dout (sr_adj[WIDTH + BCD_DIGIT_W*g +: BCD_DIGIT_W])
      );
   end

   assign bcd_final   = ovf_pend ? ALL_NINES : sr[SR_W-1:WIDTH];
   assign blank_final = blank_of(bcd_final);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         cnt      <= '0;
         sr       <= '0;
         ovf_pend <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         bcd_q    <= '0;
         ovf_q    <= 1'b0;
         blank_q  <= BLANK_RST;
      end else begin
         done_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  sr       <= SR_W'(bus.bin);
                  cnt      <= CNT_W'(WIDTH);
                  ovf_pend <= ovf_cmp;
                  busy_q   <= 1'b1;
                  state    <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               sr  <= sr_adj << 1;
               cnt <= cnt - 1'b1;
               if (cnt == CNT_W'(1)) begin
                  state <= S_DONE;
               end
            end
            S_DONE: begin
               bcd_q   <= bcd_final;
               ovf_q   <= ovf_pend;
               blank_q <= blank_final;
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state   <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
   assign bus.bcd   = bcd_q;
   assign bus.ovf   = ovf_q;
   assign bus.blank = blank_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// -----------------------------------------------------------------------------
// tb_bin_to_bcd_seq
// Directed bench for bin_to_bcd_seq in three configurations:
//   u83 : WIDTH=8, DIGITS=3    u82 : WIDTH=8, DIGITS=2    u52 : WIDTH=5, DIGITS=2
// -----------------------------------------------------------------------------
module tb_bin_to_bcd_seq;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   int   done52_cnt;

   bin_to_bcd_seq_if #(.WIDTH(8), .DIGITS(3)) if83 ();
   bin_to_bcd_seq_if #(.WIDTH(8), .DIGITS(2)) if82 ();
   bin_to_bcd_seq_if #(.WIDTH(5), .DIGITS(2)) if52 ();

   bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) u83 (.clk(clk), .rst(rst), .bus(if83.slave));
   bin_to_bcd_seq #(.WIDTH(8), .DIGITS(2)) u82 (.clk(clk), .rst(rst), .bus(if82.slave));
   bin_to_bcd_seq #(.WIDTH(5), .DIGITS(2)) u52 (.clk(clk), .rst(rst), .bus(if52.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rst) done52_cnt <= 0;
      else if (if52.done) done52_cnt <= done52_cnt + 1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, got timeout required finish");
      $fatal(1);
   end

   typedef struct {
      int          w;
      logic [7:0]  b;
      logic [11:0] bcd;
      logic        ovf;
      logic [2:0]  blank;
   } vec_t;

   vec_t vecs[12];

   function automatic logic [11:0] get_bcd(int w);
      case (w)
         0:       return if83.bcd;
         1:       return {4'h0, if82.bcd};
         default: return {4'h0, if52.bcd};
      endcase
   endfunction

   function automatic logic [2:0] get_blank(int w);
      case (w)
         0:       return if83.blank;
         1:       return {1'b0, if82.blank};
         default: return {1'b0, if52.blank};
      endcase
   endfunction

   function automatic logic get_done(int w);
      case (w)
         0:       return if83.done;
         1:       return if82.done;
         default: return if52.done;
      endcase
   endfunction

   function automatic logic get_busy(int w);
      case (w)
         0:       return if83.busy;
         1:       return if82.busy;
         default: return if52.busy;
      endcase
   endfunction

   function automatic logic get_ovf(int w);
      case (w)
         0:       return if83.ovf;
         1:       return if82.ovf;
         default: return if52.ovf;
      endcase
   endfunction

   task automatic set_in(int w, logic s, logic [7:0] b);
      case (w)
         0:       begin if83.start = s; if83.bin = b;      end
         1:       begin if82.start = s; if82.bin = b;      end
         default: begin if52.start = s; if52.bin = b[4:0]; end
      endcase
   endtask

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Caller is at the negedge after the accepting edge (cycle 0). Waits for
   // done, checking busy stays high until then, and returns the cycle index.
   task automatic wait_done(int w, output int c, output bit busy_ok);
      c       = 0;
      busy_ok = 1'b1;
      while (!get_done(w) && c < 40) begin
         if (get_busy(w) !== 1'b1) busy_ok = 1'b0;
         c++;
         @(negedge clk);
      end
   endtask

   task automatic run_conv(int w, logic [7:0] b, logic [11:0] eb, logic eo,
                           logic [2:0] ebl, string nm);
      int c;
      bit bok;
      int wd;
      wd = (w == 2) ? 5 : 8;
      @(negedge clk);
      set_in(w, 1'b1, b);
      @(posedge clk);
      @(negedge clk);
      set_in(w, 1'b0, b);
      wait_done(w, c, bok);
      chk({nm, " latency"}, c, wd + 1);
      chk({nm, " busy window"}, {31'd0, bok}, 32'd1);
      chk({nm, " bcd"}, {20'd0, get_bcd(w)}, {20'd0, eb});
      chk({nm, " ovf"}, {31'd0, get_ovf(w)}, {31'd0, eo});
      chk({nm, " blank"}, {29'd0, get_blank(w)}, {29'd0, ebl});
      chk({nm, " busy at done"}, {31'd0, get_busy(w)}, 32'd0);
      @(negedge clk);
      chk({nm, " done single pulse"}, {31'd0, get_done(w)}, 32'd0);
      chk({nm, " bcd hold"}, {20'd0, get_bcd(w)}, {20'd0, eb});
   endtask

   initial begin
      int c;
      bit bok;
      int nd;
      logic [11:0] e;

      checks = 0;
      errors = 0;
      vecs[0]  = '{0, 8'd255, 12'h255, 1'b0, 3'b000};
      vecs[1]  = '{0, 8'd0,   12'h000, 1'b0, 3'b110};
      vecs[2]  = '{0, 8'd7,   12'h007, 1'b0, 3'b110};
      vecs[3]  = '{0, 8'd40,  12'h040, 1'b0, 3'b100};
      vecs[4]  = '{0, 8'd100, 12'h100, 1'b0, 3'b000};
      vecs[5]  = '{0, 8'd209, 12'h209, 1'b0, 3'b000};
      vecs[6]  = '{1, 8'd99,  12'h099, 1'b0, 3'b000};
      vecs[7]  = '{1, 8'd100, 12'h099, 1'b1, 3'b000};
      vecs[8]  = '{1, 8'd123, 12'h099, 1'b1, 3'b000};
      vecs[9]  = '{1, 8'd5,   12'h005, 1'b0, 3'b010};
      vecs[10] = '{1, 8'd0,   12'h000, 1'b0, 3'b010};
      vecs[11] = '{1, 8'd255, 12'h099, 1'b1, 3'b000};

      rst = 1'b1;
      set_in(0, 1'b0, 8'd0);
      set_in(1, 1'b0, 8'd0);
      set_in(2, 1'b0, 8'd0);
      repeat (3) @(negedge clk);

      // Reset state
      chk("rst busy83",  {31'd0, if83.busy}, 32'd0);
      chk("rst done83",  {31'd0, if83.done}, 32'd0);
      chk("rst bcd83",   {20'd0, if83.bcd},  32'd0);
      chk("rst ovf83",   {31'd0, if83.ovf},  32'd0);
      chk("rst blank83", {29'd0, if83.blank}, 32'd6);
      chk("rst blank82", {30'd0, if82.blank}, 32'd2);
      chk("rst blank52", {30'd0, if52.blank}, 32'd2);
      rst = 1'b0;

      // Table-driven vectors
      for (int i = 0; i < 12; i++) begin
         run_conv(vecs[i].w, vecs[i].b, vecs[i].bcd, vecs[i].ovf, vecs[i].blank,
                  $sformatf("vec%0d bin=%0d", i, vecs[i].b));
      end

      // W=5,D=2 sweep with start held high: back-to-back conversions
      @(negedge clk);
      set_in(2, 1'b1, 8'd0);
      for (int v = 0; v < 32; v++) begin
         @(posedge clk);
         @(negedge clk);
         if (v == 31) set_in(2, 1'b0, 8'd0);
         else         set_in(2, 1'b1, 8'(v + 1));
         wait_done(2, c, bok);
         e = {4'h0, 4'(v / 10), 4'(v % 10)};
         chk($sformatf("sweep%0d latency", v), c, 6);
         chk($sformatf("sweep%0d busy", v), {31'd0, bok}, 32'd1);
         chk($sformatf("sweep%0d bcd", v), {20'd0, get_bcd(2)}, {20'd0, e});
         chk($sformatf("sweep%0d ovf", v), {31'd0, get_ovf(2)}, 32'd0);
         chk($sformatf("sweep%0d blank", v), {29'd0, get_blank(2)},
             (v < 10) ? 32'd2 : 32'd0);
      end
      repeat (10) @(negedge clk);
      chk("sweep done count", done52_cnt, 32);

      // Start during conversion is ignored, bin changes have no effect
      @(negedge clk);
      set_in(0, 1'b1, 8'd200);
      @(posedge clk);
      @(negedge clk);
      set_in(0, 1'b0, 8'd17);
      c  = 0;
      nd = 0;
      while (!if83.done && c < 40) begin
         if (c == 2) if83.start = 1'b1;
         else        if83.start = 1'b0;
         if83.bin = 8'($urandom_range(0, 255));
         c++;
         @(negedge clk);
      end
      if83.start = 1'b0;
      chk("ignore latency", c, 9);
      chk("ignore bcd", {20'd0, if83.bcd}, 32'h200);
      chk("ignore blank", {29'd0, if83.blank}, 32'd0);
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         if (if83.done === 1'b1 || if83.busy === 1'b1) nd++;
      end
      chk("ignore not queued", nd, 0);

      // Reset during SHIFT aborts without done
      @(negedge clk);
      set_in(0, 1'b1, 8'd123);
      @(posedge clk);
      @(negedge clk);
      set_in(0, 1'b0, 8'd123);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("abort busy",  {31'd0, if83.busy}, 32'd0);
      chk("abort done",  {31'd0, if83.done}, 32'd0);
      chk("abort bcd",   {20'd0, if83.bcd},  32'd0);
      chk("abort blank", {29'd0, if83.blank}, 32'd6);
      rst = 1'b0;
      nd = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (if83.done === 1'b1) nd++;
      end
      chk("abort no done", nd, 0);
      run_conv(0, 8'd58, 12'h058, 1'b0, 3'b100, "after abort bin=58");

      // Reset and start in the same cycle: reset wins
      @(negedge clk);
      rst = 1'b1;
      set_in(0, 1'b1, 8'd99);
      @(negedge clk);
      rst = 1'b0;
      set_in(0, 1'b0, 8'd99);
      chk("rst+start busy", {31'd0, if83.busy}, 32'd0);
      chk("rst+start bcd",  {20'd0, if83.bcd},  32'd0);
      @(negedge clk);
      chk("rst+start stays idle", {31'd0, if83.busy}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
